// File: rtl/parity_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_monitor_pkg
//  Description : Shared index constants for the parity monitor front panel.
//                Button indices select bits of the btn bus and LED indices
//                select bits of the led bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_monitor_pkg;

    // Button command positions on btn[3:0]
    localparam int BTN_MODE = 0;
    localparam int BTN_CAP  = 1;
    localparam int BTN_CLR  = 2;
    localparam int BTN_HOLD = 3;
    localparam int NUM_BTN  = 4;

    // LED positions on led[2:0]
    localparam int LED_PAR  = 0;
    localparam int LED_MIS  = 1;
    localparam int LED_MODE = 2;
    localparam int NUM_LED  = 3;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Single-button debouncer. The stable level only follows the
//                (already synchronised) input after it has differed from the
//                stable level for DEBOUNCE consecutive cycles. A one-cycle
//                press pulse accompanies every accepted rising transition.
//  Ports       : clk   - system clock
//                rst   - asynchronous active-high reset
//                din   - synchronised raw button level
//                level - debounced stable level
//                press - 1-cycle pulse on an accepted 0->1 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import parity_monitor_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int              c_CNT_W    = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (din != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    // Input has disagreed for DEBOUNCE cycles: accept it.
                    r_level <= din;
                    r_cnt   <= '0;
                    r_press <= din;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/parity_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : parity_monitor
//  Description : Masked parity monitor for front-panel switches. Switches and
//                buttons are synchronised, buttons debounced into commands
//                (mode toggle, capture reference, clear, hold) and mismatch
//                events against the captured reference are counted in a
//                saturating counter.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-high reset
//                sw        - raw switches (asynchronous)
//                btn       - raw buttons [0] mode [1] capture [2] clear [3] hold
//                led       - [0] parity [1] mismatch [2] odd-mode
//                err_count - saturating mismatch-event count
//                ref_valid - reference parity captured and active
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_monitor
    import parity_monitor_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MASK     = WIDTH'(8'h55),
    parameter int               DEBOUNCE = 16,
    parameter int               CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       btn,
    output logic [2:0]       led,
    output logic [CNT_W-1:0] err_count,
    output logic             ref_valid
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Two-flop synchronisers
    logic [WIDTH-1:0]   r_sw_meta;
    logic [WIDTH-1:0]   r_sw_sync;
    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debouncers
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (r_btn_sync[gi]),
            .level (w_level[gi]),
            .press (w_press[gi])
        );
    end

    // Only the hold button is used as a level; only the others as presses.
    logic w_unused_btn;
    assign w_unused_btn = ^{w_level[BTN_CLR:BTN_MODE], w_press[BTN_HOLD]};

    // Parity and mismatch
    logic w_par_raw;
    logic w_mis;
    logic w_mis_rise;

    logic             r_mode;
    logic             r_par;
    logic             r_mis;
    logic             r_mis_d;
    logic             r_ref_par;
    logic             r_ref_valid;
    logic [CNT_W-1:0] r_err;

    assign w_par_raw  = ^(r_sw_sync & MASK);
    assign w_mis      = r_ref_valid & (w_par_raw != r_ref_par);
    // Edge of the registered mismatch; r_mis_d keeps tracking during hold so
    // a mismatch that is already high when hold releases never counts.
    assign w_mis_rise = r_mis & ~r_mis_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_par       <= 1'b0;
            r_mis       <= 1'b0;
            r_mis_d     <= 1'b0;
            r_ref_par   <= 1'b0;
            r_ref_valid <= 1'b0;
            r_err       <= '0;
        end else begin
            r_par   <= w_par_raw ^ r_mode;
            r_mis   <= w_mis;
            r_mis_d <= r_mis;

            if (w_press[BTN_MODE]) begin
                r_mode <= ~r_mode;
            end

            // Clear beats capture, capture beats a pending increment.
            if (w_press[BTN_CLR]) begin
                r_err       <= '0;
                r_ref_valid <= 1'b0;
            end else if (w_press[BTN_CAP]) begin
                r_ref_par   <= w_par_raw;
                r_ref_valid <= 1'b1;
            end else if (w_mis_rise && !w_level[BTN_HOLD] && (r_err != c_CNT_MAX)) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

    always_comb begin
        led           = '0;
        led[LED_PAR]  = r_par;
        led[LED_MIS]  = r_mis;
        led[LED_MODE] = r_mode;
    end

    assign err_count = r_err;
    assign ref_valid = r_ref_valid;

endmodule
`default_nettype wire

// File: tb/tb_parity_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_monitor
//  Description : Self-checking bench for parity_monitor (WIDTH=8, MASK=8'h55,
//                DEBOUNCE=4, CNT_W=4). Parity table with latency, hand-written
//                debounce/reset/counting/priority sequences, then random
//                commands against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_monitor;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] MASK     = 8'h55;
    localparam int         DEBOUNCE = 4;
    localparam int         CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic [3:0]       btn;
    logic [2:0]       led;
    logic [CNT_W-1:0] err_count;
    logic             ref_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parity_monitor #(
        .WIDTH    (WIDTH),
        .MASK     (MASK),
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .err_count (err_count),
        .ref_valid (ref_valid)
    );

    typedef struct {
        logic [7:0] sw;
        logic       par;
    } par_vec_t;

    par_vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] v);
        return ($countones(v & MASK) % 2) == 1;
    endfunction

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        tick(8);
        btn[idx] = 1'b0;
        tick(8);
    endtask

    task automatic set_sw(input logic [7:0] v);
        sw = v;
        tick(6);
    endtask

    // Behavioural model state for the random phase
    logic       m_mode, m_ref, m_valid, m_hold;
    int         m_cnt;
    logic [7:0] m_sw;

    initial begin
        rst = 1'b0;
        sw  = '0;
        btn = '0;

        // ---- Reset state ----
        #2 rst = 1'b1;
        #1;
        check("reset_led", led, 3'b000);
        check("reset_cnt", err_count, 0);
        check("reset_valid", ref_valid, 0);
        tick(2);
        rst = 1'b0;
        tick(4);

        // ---- Parity table with 3-cycle latency ----
        vecs[0] = '{8'h01, 1'b1};
        vecs[1] = '{8'h05, 1'b0};
        vecs[2] = '{8'h02, 1'b0};
        vecs[3] = '{8'h54, 1'b1};
        vecs[4] = '{8'h55, 1'b0};
        vecs[5] = '{8'hAA, 1'b0};
        vecs[6] = '{8'h10, 1'b1};
        vecs[7] = '{8'h02, 1'b0};
        begin
            logic prev;
            prev = 1'b0;
            for (int i = 0; i < 8; i++) begin
                sw = vecs[i].sw;
                tick(2);
                check($sformatf("par_hold_%0d", i), led[0], prev);
                tick(1);
                check($sformatf("par_%0d", i), led[0], vecs[i].par);
                prev = vecs[i].par;
            end
        end

        // ---- Mode toggle with masked-only switch ----
        press(0);
        check("mode_led", led, 3'b101);

        // ---- Debounce: glitch, clean press, bounce on release ----
        btn[0] = 1'b1; tick(3); btn[0] = 1'b0; tick(10);
        check("glitch_no_toggle", led[2], 1'b1);
        btn[0] = 1'b1; tick(6);
        btn[0] = 1'b0; tick(2); btn[0] = 1'b1; tick(2);
        btn[0] = 1'b0; tick(1); btn[0] = 1'b1; tick(1);
        btn[0] = 1'b0; tick(12);
        check("press_one_toggle", led[2], 1'b0);

        // ---- Mismatch counting ----
        set_sw(8'h00);
        press(1);
        check("cap_valid", ref_valid, 1'b1);
        check("cap_mis", led[1], 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_sw(8'h01);
            check($sformatf("mis_hi_%0d", i), led[1], 1'b1);
            if (i == 2) press(0);
            set_sw(8'h00);
            check($sformatf("mis_lo_%0d", i), led[1], 1'b0);
        end
        check("count_5", err_count, 5);

        // ---- Asynchronous reset mid-debounce with a button held ----
        btn[0] = 1'b1;
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("midrst_led", led, 3'b000);
        check("midrst_cnt", err_count, 0);
        check("midrst_valid", ref_valid, 0);
        tick(2);
        rst = 1'b0;
        begin
            int first, toggles;
            logic last;
            first = 0; toggles = 0; last = led[2];
            for (int c = 1; c <= 30; c++) begin
                tick(1);
                if (led[2] != last) toggles++;
                if (led[2] && first == 0) first = c;
                last = led[2];
            end
            check("requal_latency_ok", (first >= 6 && first <= 8), 1);
            check("requal_one_toggle", toggles, 1);
        end
        btn[0] = 1'b0;
        tick(10);

        // ---- Saturation ----
        set_sw(8'h00);
        press(1);
        for (int i = 0; i < 20; i++) begin
            set_sw(8'h01);
            set_sw(8'h00);
            if (i == 9) check("count_10", err_count, 10);
        end
        check("count_sat", err_count, 15);

        // ---- Hold ----
        press(2);
        check("clr_cnt", err_count, 0);
        check("clr_valid", ref_valid, 0);
        press(1);
        btn[3] = 1'b1; tick(10);
        for (int i = 0; i < 3; i++) begin
            set_sw(8'h01);
            if (i < 2) set_sw(8'h00);
        end
        check("hold_cnt", err_count, 0);
        check("hold_mis_level", led[1], 1'b1);
        btn[3] = 1'b0; tick(10);
        check("hold_release_cnt", err_count, 0);
        set_sw(8'h00);
        set_sw(8'h01);
        check("after_hold_cnt", err_count, 1);
        set_sw(8'h00);

        // ---- Capture and clear in the same cycle ----
        btn[1] = 1'b1; btn[2] = 1'b1; tick(8);
        btn[1] = 1'b0; btn[2] = 1'b0; tick(8);
        check("capclr_valid", ref_valid, 0);
        check("capclr_cnt", err_count, 0);

        // ---- Capture coinciding with a mismatch edge ----
        press(1);
        btn[1] = 1'b1;
        tick(3);
        sw = 8'h01;
        tick(10);
        btn[1] = 1'b0;
        tick(10);
        check("capedge_cnt", err_count, 0);
        check("capedge_valid", ref_valid, 1);
        check("capedge_mis", led[1], 1'b0);

        // ---- Random commands against the model ----
        #2 rst = 1'b1;
        tick(2);
        rst = 1'b0; btn = '0; sw = '0;
        tick(4);
        m_mode = 0; m_ref = 0; m_valid = 0; m_hold = 0; m_cnt = 0; m_sw = '0;
        for (int s = 0; s < 80; s++) begin
            int act;
            logic mis_old, mis_new;
            act = $urandom_range(0, 6);
            case (act)
                0, 1, 2: begin
                    logic [7:0] v;
                    v = 8'($urandom);
                    mis_old = m_valid && (model_parity(m_sw) != m_ref);
                    mis_new = m_valid && (model_parity(v) != m_ref);
                    if (!mis_old && mis_new && !m_hold && m_cnt < 15) m_cnt++;
                    m_sw = v;
                    set_sw(v);
                end
                3: begin m_mode = ~m_mode; press(0); end
                4: begin m_ref = model_parity(m_sw); m_valid = 1; press(1); end
                5: begin m_cnt = 0; m_valid = 0; press(2); end
                default: begin m_hold = ~m_hold; btn[3] = m_hold; tick(10); end
            endcase
            check($sformatf("rnd_led_%0d", s), led,
                  {m_mode, m_valid && (model_parity(m_sw) != m_ref), model_parity(m_sw) ^ m_mode});
            check($sformatf("rnd_cnt_%0d", s), err_count, m_cnt);
            check($sformatf("rnd_valid_%0d", s), ref_valid, m_valid);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
